// File: rtl/otter_dmem_arbiter_pkg.sv
// otter_dmem_arbiter_pkg
//   Shared types and constants for the OtterMCU data-memory arbiter.
//   - arb_state_e   : arbiter FSM states (IDLE / RD_WAIT)
//   - DMEM_REQ_*    : requester IDs (core = 0, debug/DMA = 1)
//   - dmem_req_t    : one requester's access payload
//   - word_addr()   : byte address -> word-aligned BRAM address
package otter_dmem_arbiter_pkg;

  localparam int NUM_REQ = 2;
  localparam int CNT_W   = 2;  // holds RD_LATENCY-1 for RD_LATENCY in 1..4

  localparam logic DMEM_REQ_CORE = 1'b0;
  localparam logic DMEM_REQ_DBG  = 1'b1;

  typedef enum logic {
    DMEM_ARB_IDLE    = 1'b0,
    DMEM_ARB_RD_WAIT = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] w_data;
  } dmem_req_t;

  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/otter_dmem_arbiter_if.sv
// otter_dmem_arbiter_if
//   Bundles the two requester handshakes and the BRAM port of the data
//   memory arbiter.
//   - req0_* : core load/store unit (valid/ready, we, sel, addr, w_data,
//              rsp_valid, r_data)
//   - req1_* : debug/DMA master, same fields
//   - mem_*  : synchronous BRAM port (en, we, addr, w_data, r_data)
//   - owner  : requester currently granted or waited on
//   Modports: slave = the arbiter, master = requesters + memory.
interface otter_dmem_arbiter_if;

  logic        req0_valid, req0_ready, req0_we;
  logic [3:0]  req0_sel;
  logic [31:0] req0_addr, req0_w_data;
  logic        req0_rsp_valid;
  logic [31:0] req0_r_data;

  logic        req1_valid, req1_ready, req1_we;
  logic [3:0]  req1_sel;
  logic [31:0] req1_addr, req1_w_data;
  logic        req1_rsp_valid;
  logic [31:0] req1_r_data;

  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_w_data, mem_r_data;
  logic        owner;

  modport slave (
    input  req0_valid, req0_we, req0_sel, req0_addr, req0_w_data,
    input  req1_valid, req1_we, req1_sel, req1_addr, req1_w_data,
    input  mem_r_data,
    output req0_ready, req0_rsp_valid, req0_r_data,
    output req1_ready, req1_rsp_valid, req1_r_data,
    output mem_en, mem_we, mem_addr, mem_w_data, owner
  );

  modport master (
    output req0_valid, req0_we, req0_sel, req0_addr, req0_w_data,
    output req1_valid, req1_we, req1_sel, req1_addr, req1_w_data,
    output mem_r_data,
    input  req0_ready, req0_rsp_valid, req0_r_data,
    input  req1_ready, req1_rsp_valid, req1_r_data,
    input  mem_en, mem_we, mem_addr, mem_w_data, owner
  );

endinterface

// File: rtl/otter_dmem_arbiter_rr_arb2.sv
// otter_rr_arb2
//   Two-input one-hot grant logic for the data-memory arbiter.
//   A lone requester always wins. On a tie the policy depends on
//   OTTER_DMEM_ARB_RR_EN:
//     defined   : round-robin, grant the requester not granted last; the
//                 last-grant pointer resets to 1 so requester 0 wins the
//                 first tie and updates on every accept.
//     undefined : fixed priority, requester 0 always wins (no pointer).
//   Ports:
//     i_clk, i_rst_n : clock, async active-low reset
//     i_req[1:0]     : eligible requests (already masked by arbiter state)
//     i_accept       : a grant was taken this cycle
//     o_gnt[1:0]     : one-hot grant (0 when no request)
module otter_rr_arb2
  import otter_dmem_arbiter_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_gnt
);

`ifdef OTTER_DMEM_ARB_RR_EN
  logic last_q, last_d;

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = last_q ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
    last_d = i_accept ? o_gnt[1] : last_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) last_q <= DMEM_REQ_DBG;
    else          last_q <= last_d;
  end
`else
  // Core wins every tie; the debug master waits for a gap.
  assign o_gnt = i_req[0] ? 2'b01 : {i_req[1], 1'b0};

  logic unused;
  assign unused = &{1'b0, i_clk, i_rst_n, i_accept};
`endif

endmodule

// File: rtl/otter_dmem_arbiter.sv
// otter_dmem_arbiter
//   Shares the single OtterMCU data-memory BRAM port between the core
//   load/store unit (requester 0) and the debug/DMA master (requester 1).
//   One access at a time: stores complete in the accept cycle and are
//   acked one cycle later; loads park the FSM in RD_WAIT for RD_LATENCY
//   cycles and then route i_mem_r_data to the owner combinationally.
//   Tie policy is chosen by macro OTTER_DMEM_ARB_RR_EN (see otter_rr_arb2).
//   Parameters:
//     RD_LATENCY : BRAM read latency in cycles, legal 1..4
//   Ports:
//     i_clk, i_rst_n : clock, asynchronous active-low reset
//     bus            : otter_dmem_arbiter_if.slave (requesters, BRAM, owner)
module otter_dmem_arbiter
  import otter_dmem_arbiter_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  otter_dmem_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(RD_LATENCY - 1);

  arb_state_e                      state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            owner_q, owner_d;
  logic [NUM_REQ-1:0]              ack_q, ack_d;

  logic [NUM_REQ-1:0]              valid, arb_req, gnt, rd_rsp, rsp_valid;
  logic [NUM_REQ-1:0][31:0]        r_data;
  dmem_req_t [NUM_REQ-1:0]         req_pl;
  dmem_req_t                       sel_req;
  logic                            accept, gidx, rd_done;

  assign valid     = {bus.req1_valid, bus.req0_valid};
  assign req_pl[0] = {bus.req0_we, bus.req0_sel, bus.req0_addr, bus.req0_w_data};
  assign req_pl[1] = {bus.req1_we, bus.req1_sel, bus.req1_addr, bus.req1_w_data};

  // Only offer requests while idle and out of reset; gating here keeps
  // readies, mem_en and mem_we low throughout reset.
  assign arb_req = (state_q == DMEM_ARB_IDLE && i_rst_n) ? valid : '0;

  otter_rr_arb2 u_arb (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_req    (arb_req),
    .i_accept (accept),
    .o_gnt    (gnt)
  );

  assign accept  = |gnt;
  assign gidx    = gnt[1];
  assign sel_req = req_pl[gidx];

  // Memory side: granted payload passes straight through in the accept cycle.
  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];
  assign bus.mem_en     = accept;
  assign bus.mem_we     = (accept && sel_req.we) ? sel_req.sel : 4'h0;
  assign bus.mem_addr   = word_addr(sel_req.addr);
  assign bus.mem_w_data = sel_req.w_data;
  assign bus.owner      = accept ? gidx : owner_q;

  // Read response fires in the cycle the counter reaches zero.
  assign rd_done = (state_q == DMEM_ARB_RD_WAIT) && (cnt_q == '0);
  assign rd_rsp  = rd_done ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    rsp_valid = ack_q | rd_rsp;
    r_data    = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (rd_rsp[i]) r_data[i] = bus.mem_r_data;
  end

  assign bus.req0_rsp_valid = rsp_valid[0];
  assign bus.req1_rsp_valid = rsp_valid[1];
  assign bus.req0_r_data    = r_data[0];
  assign bus.req1_r_data    = r_data[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    ack_d   = '0;
    case (state_q)
      DMEM_ARB_IDLE: begin
        if (accept) begin
          if (sel_req.we) begin
            ack_d[gidx] = 1'b1;
          end else begin
            state_d = DMEM_ARB_RD_WAIT;
            cnt_d   = LAT_M1;
            owner_d = gidx;
          end
        end
      end
      DMEM_ARB_RD_WAIT: begin
        if (cnt_q == '0) state_d = DMEM_ARB_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = DMEM_ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= DMEM_ARB_IDLE;
      cnt_q   <= '0;
      owner_q <= DMEM_REQ_CORE;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      ack_q   <= ack_d;
    end
  end

endmodule

// File: tb/tb_otter_dmem_arbiter.sv
// tb_otter_dmem_arbiter
//   Directed + random stimulus for otter_dmem_arbiter (RD_LATENCY = 2).
//   A transaction-level model predicts, per cycle, which requester is
//   accepted (free-time + tie policy), what the BRAM port carries and
//   which responses are due (a timestamped queue). A BRAM stub drives
//   i_mem_r_data from the DUT's actual memory port.
module tb_otter_dmem_arbiter;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  otter_dmem_arbiter_if bus();

  otter_dmem_arbiter #(.RD_LATENCY(LAT)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // ---------------- memory contents (stub and model kept separately) ----
  function automatic logic [31:0] pat(int w);
    logic [15:0] wl;
    wl = 16'(w);
    return {wl, ~wl};
  endfunction

  function automatic logic [31:0] merge(logic [31:0] cur, logic [31:0] d, logic [3:0] be);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  bit [31:0]   smem [256];
  bit          sval [256];
  logic [31:0] rpipe [LAT];

  function automatic logic [31:0] srd(int w);
    return sval[w] ? smem[w] : pat(w);
  endfunction

  always @(posedge clk) begin
    rpipe[0] <= 32'h0BAD_0BAD;
    if (bus.mem_en) begin
      if (bus.mem_we != 4'h0) begin
        smem[bus.mem_addr[9:2]] <= merge(srd(int'(bus.mem_addr[9:2])), bus.mem_w_data, bus.mem_we);
        sval[bus.mem_addr[9:2]] <= 1'b1;
      end else begin
        rpipe[0] <= srd(int'(bus.mem_addr[9:2]));
      end
    end
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign bus.mem_r_data = rpipe[LAT-1];

  bit [31:0] mmem [256];
  bit        mval [256];

  function automatic logic [31:0] mrd(int w);
    return mval[w] ? mmem[w] : pat(w);
  endfunction

  // ---------------- checking ----------------
  int n_chk, n_pass, n_fail;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(string tag);
    chk({tag, ".ready0"}, bus.req0_ready, 0);
    chk({tag, ".ready1"}, bus.req1_ready, 0);
    chk({tag, ".mem_en"}, bus.mem_en, 0);
    chk({tag, ".mem_we"}, bus.mem_we, 0);
    chk({tag, ".rsp0"},   bus.req0_rsp_valid, 0);
    chk({tag, ".rsp1"},   bus.req1_rsp_valid, 0);
    chk({tag, ".rdata0"}, bus.req0_r_data, 0);
    chk({tag, ".rdata1"}, bus.req1_r_data, 0);
    chk({tag, ".owner"},  bus.owner, 0);
  endtask

  // ---------------- requesters ----------------
  bit          rq_v   [2];
  bit          rq_we  [2];
  logic [3:0]  rq_sel [2];
  logic [31:0] rq_addr[2];
  logic [31:0] rq_wd  [2];

  task automatic drive();
    bus.req0_valid = rq_v[0]; bus.req0_we = rq_we[0]; bus.req0_sel = rq_sel[0];
    bus.req0_addr  = rq_addr[0]; bus.req0_w_data = rq_wd[0];
    bus.req1_valid = rq_v[1]; bus.req1_we = rq_we[1]; bus.req1_sel = rq_sel[1];
    bus.req1_addr  = rq_addr[1]; bus.req1_w_data = rq_wd[1];
  endtask

  task automatic req(int who, bit we, logic [3:0] sel, logic [31:0] addr, logic [31:0] wd);
    rq_v[who] = 1'b1; rq_we[who] = we; rq_sel[who] = sel;
    rq_addr[who] = addr; rq_wd[who] = wd;
    drive();
  endtask

  // ---------------- reference model ----------------
  typedef struct { int cyc; int who; logic [31:0] data; } rsp_t;
  rsp_t pend[$];
  int   now, free_cyc, last, lat_owner;

  task automatic model_reset();
    pend.delete();
    free_cyc  = now;
    last      = 1;
    lat_owner = 0;
  endtask

  // One clock cycle: predict, compare at negedge, advance model at posedge.
  task automatic cycle();
    int          g;
    bit          acc;
    logic [1:0]  exp_rv;
    logic [31:0] exp_rd [2];
    rsp_t        r;
    drive();
    acc = 1'b0;
    g   = 0;
    if (now >= free_cyc && (rq_v[0] || rq_v[1])) begin
      acc = 1'b1;
      if (rq_v[0] && rq_v[1]) begin
`ifdef OTTER_DMEM_ARB_RR_EN
        g = 1 - last;
`else
        g = 0;
`endif
      end else begin
        g = rq_v[1] ? 1 : 0;
      end
    end
    exp_rv = 2'b00; exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
    foreach (pend[i])
      if (pend[i].cyc == now) begin
        exp_rv[pend[i].who] = 1'b1;
        exp_rd[pend[i].who] = pend[i].data;
      end

    @(negedge clk);
    chk("ready0", bus.req0_ready, 32'(acc && g == 0));
    chk("ready1", bus.req1_ready, 32'(acc && g == 1));
    chk("mem_en", bus.mem_en, 32'(acc));
    chk("mem_we", bus.mem_we, (acc && rq_we[g]) ? rq_sel[g] : 4'h0);
    if (acc) begin
      chk("mem_addr",   bus.mem_addr,   {rq_addr[g][31:2], 2'b00});
      chk("mem_w_data", bus.mem_w_data, rq_wd[g]);
    end
    chk("owner",  bus.owner, acc ? g : lat_owner);
    chk("rsp0",   bus.req0_rsp_valid, 32'(exp_rv[0]));
    chk("rsp1",   bus.req1_rsp_valid, 32'(exp_rv[1]));
    chk("rdata0", bus.req0_r_data, exp_rd[0]);
    chk("rdata1", bus.req1_r_data, exp_rd[1]);

    @(posedge clk);
    if (acc) begin
      last = g;
      r.who = g;
      if (rq_we[g]) begin
        mmem[rq_addr[g][9:2]] = merge(mrd(int'(rq_addr[g][9:2])), rq_wd[g], rq_sel[g]);
        mval[rq_addr[g][9:2]] = 1'b1;
        r.cyc  = now + 1;
        r.data = 32'h0;
      end else begin
        r.cyc     = now + LAT;
        r.data    = mrd(int'(rq_addr[g][9:2]));
        free_cyc  = now + LAT + 1;
        lat_owner = g;
      end
      pend.push_back(r);
      rq_v[g] = 1'b0;
    end
    while (pend.size() > 0 && pend[0].cyc <= now) void'(pend.pop_front());
    now++;
    #1;
    drive();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0; now = 0;
    model_reset();

    // Both requesters valid during reset: nothing may be granted.
    req(0, 1'b1, 4'hF, 32'h40, 32'h1111_0000);
    req(1, 1'b1, 4'hF, 32'h44, 32'h2222_0000);
    #12;
    chk_reset("rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    // First tie after reset: core wins under either policy, debug follows.
    cycle(); cycle(); cycle();

    // Debug stores 0xDEADBEEF at 0x104, core loads it back.
    req(1, 1'b1, 4'hF, 32'h0000_0104, 32'hDEAD_BEEF);
    cycle();
    req(0, 1'b0, 4'hF, 32'h0000_0104, 32'h0);
    repeat (LAT + 1) cycle();

    // Half-word store, then a load that coincides with its ack.
    req(0, 1'b1, 4'b0011, 32'h20, 32'h0000_1234);
    cycle();
    req(0, 1'b0, 4'hF, 32'h22, 32'h0);
    repeat (LAT + 1) cycle();

    // Both stream stores: alternation (RR) or core-only (fixed).
    repeat (8) begin
      if (!rq_v[0]) req(0, 1'b1, 4'($urandom), 32'($urandom_range(0, 1023)), $urandom);
      if (!rq_v[1]) req(1, 1'b1, 4'($urandom), 32'($urandom_range(0, 1023)), $urandom);
      cycle();
    end
    repeat (3) cycle();

    // Debug load pending; core arrives during RD_WAIT and must wait.
    req(1, 1'b0, 4'hF, 32'h0000_0104, 32'h0);
    cycle();
    req(0, 1'b1, 4'hF, 32'h30, 32'hCAFE_F00D);
    repeat (LAT + 2) cycle();

    // Reset pulsed during a pending core load: response is dropped.
    req(0, 1'b0, 4'hF, 32'h0000_0104, 32'h0);
    cycle();
    req(1, 1'b1, 4'hF, 32'h50, 32'h5555_AAAA);
    #2 rst_n = 1'b0;
    #1 chk_reset("midrst");
    @(posedge clk);
    now++;
    #1 rst_n = 1'b1;
    model_reset();
    repeat (LAT + 2) cycle();
    req(0, 1'b0, 4'hF, 32'h0000_0104, 32'h0);
    repeat (LAT + 1) cycle();

    // Random traffic.
    repeat (400) begin
      for (int w = 0; w < 2; w++)
        if (!rq_v[w] && $urandom_range(0, 1) == 1)
          req(w, 1'($urandom_range(0, 1)), 4'($urandom),
              32'($urandom_range(0, 1023)), $urandom);
      cycle();
    end
    rq_v[0] = 1'b0; rq_v[1] = 1'b0;
    repeat (LAT + 2) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
